spi_rx_word_assembler: RTL and testbench

//  Downstream stage of the on-board SPI link. Samples the external sclk/mosi/ss pins in the clk domain.

---
 rtl/spi_pkg.sv | 13 +
 rtl/spi_pin_sync.sv | 40 ++++
 rtl/spi_rx_word_assembler.sv | 146 ++++++++++++++
 tb/tb_spi_rx_word_assembler.sv | 266 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/spi_pkg.sv
// Shared types and constants for the SPI receive word assembler.
package spi_pkg;

    localparam int BYTE_W = 8;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        SHIFT   = 2'd1,
        DONE    = 2'd2,
        WAIT_SS = 2'd3
    } rx_state_t;

endpackage

// File: rtl/spi_pin_sync.sv
// Multi-flop synchroniser for the asynchronous sclk/mosi/ss pins.
// Produces a one-cycle sclk rise strobe with mosi taken at the same depth.
module spi_pin_sync #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic reset,
    input  logic sclk,
    input  logic mosi,
    input  logic ss,
    output logic sclk_rise,
    output logic mosi_s,
    output logic ss_act
);

    logic [SYNC_STAGES-1:0] sclk_q;
    logic [SYNC_STAGES-1:0] mosi_q;
    logic [SYNC_STAGES-1:0] ss_q;
    logic                   sclk_prev;

    // ss resets to inactive so a held-low pin looks like a fresh select after reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            sclk_q    <= '0;
            mosi_q    <= '0;
            ss_q      <= '1;
            sclk_prev <= 1'b0;
        end else begin
            sclk_q    <= {sclk_q[SYNC_STAGES-2:0], sclk};
            mosi_q    <= {mosi_q[SYNC_STAGES-2:0], mosi};
            ss_q      <= {ss_q[SYNC_STAGES-2:0], ss};
            sclk_prev <= sclk_q[SYNC_STAGES-1];
        end
    end

    assign sclk_rise = sclk_q[SYNC_STAGES-1] & ~sclk_prev;
    assign mosi_s    = mosi_q[SYNC_STAGES-1];
    assign ss_act    = ~ss_q[SYNC_STAGES-1];

endmodule

// File: rtl/spi_rx_word_assembler.sv
// SPI mode-0 receiver: assembles BYTES_PER_WORD bytes (MSB first) into one word.
// Optional stall timeout enabled by defining SPI_RX_TIMEOUT_EN.
module spi_rx_word_assembler
    import spi_pkg::*;
#(
    parameter int BYTES_PER_WORD = 2,
    parameter int SYNC_STAGES    = 2,
    parameter int TIMEOUT_CYC    = 100000
) (
    input  logic                             clk,
    input  logic                             reset,
    input  logic                             sclk,
    input  logic                             mosi,
    input  logic                             ss,
    output logic [BYTE_W*BYTES_PER_WORD-1:0] rx_data,
    output logic                             rx_valid,
    output logic                             rx_busy,
    output logic                             frame_err,
    output rx_state_t                        rx_state
);

    localparam int WORD_W     = BYTE_W * BYTES_PER_WORD;
    localparam int BYTE_CNT_W = (BYTES_PER_WORD > 1) ? $clog2(BYTES_PER_WORD) : 1;

    if (BYTES_PER_WORD < 1 || SYNC_STAGES < 2 || TIMEOUT_CYC < 1) begin : g_bad_param
        $error("spi_rx_word_assembler: illegal parameter value");
    end

    rx_state_t             state;
    rx_state_t             state_next;
    logic                  sclk_rise;
    logic                  mosi_s;
    logic                  ss_act;
    logic [2:0]            bit_cnt;
    logic [BYTE_CNT_W-1:0] byte_cnt;
    logic [WORD_W-1:0]     shift_reg;
    logic                  shift_en;
    logic                  last_bit;
    logic                  bits_pending;
    logic                  timeout_hit;
    logic                  done_now;
    logic                  err_now;

    spi_pin_sync #(
        .SYNC_STAGES(SYNC_STAGES)
    ) u_pin_sync (
        .clk      (clk),
        .reset    (reset),
        .sclk     (sclk),
        .mosi     (mosi),
        .ss       (ss),
        .sclk_rise(sclk_rise),
        .mosi_s   (mosi_s),
        .ss_act   (ss_act)
    );

    // A rise coinciding with the IDLE->SHIFT transition is already a data bit.
    assign shift_en     = sclk_rise && ss_act && (state == IDLE || state == SHIFT);
    assign last_bit     = shift_en && (bit_cnt == 3'd7) &&
                          (byte_cnt == BYTE_CNT_W'(BYTES_PER_WORD - 1));
    assign bits_pending = (bit_cnt != 3'd0) || (byte_cnt != '0);

`ifdef SPI_RX_TIMEOUT_EN
    localparam int IDLE_W = $clog2(TIMEOUT_CYC + 1);

    logic [IDLE_W-1:0] idle_cnt;

    always_ff @(posedge clk) begin
        if (reset || state != SHIFT || sclk_rise) begin
            idle_cnt <= '0;
        end else if (idle_cnt != IDLE_W'(TIMEOUT_CYC)) begin
            idle_cnt <= idle_cnt + IDLE_W'(1);
        end
    end

    assign timeout_hit = (state == SHIFT) && ss_act && bits_pending && !sclk_rise &&
                         (idle_cnt == IDLE_W'(TIMEOUT_CYC));
`else
    assign timeout_hit = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (ss_act) state_next = SHIFT;
            end
            SHIFT: begin
                if (!ss_act)          state_next = IDLE;
                else if (timeout_hit) state_next = WAIT_SS;
                else if (last_bit)    state_next = DONE;
            end
            DONE: begin
                state_next = ss_act ? SHIFT : IDLE;
            end
            WAIT_SS: begin
                if (!ss_act) state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        rx_busy  = (state != IDLE);
        rx_state = state;
        done_now = (state == DONE);
        err_now  = ((state == SHIFT) && !ss_act && bits_pending) || timeout_hit;
    end

    // Output strobes are registered; rx_data only ever changes alongside rx_valid.
    always_ff @(posedge clk) begin
        if (reset) begin
            rx_data   <= '0;
            rx_valid  <= 1'b0;
            frame_err <= 1'b0;
            bit_cnt   <= 3'd0;
            byte_cnt  <= '0;
            shift_reg <= '0;
        end else begin
            rx_valid  <= done_now;
            frame_err <= err_now;
            if (done_now) begin
                rx_data <= shift_reg;
            end
            if (done_now || err_now) begin
                bit_cnt  <= 3'd0;
                byte_cnt <= '0;
            end else if (shift_en) begin
                shift_reg <= {shift_reg[WORD_W-2:0], mosi_s};
                bit_cnt   <= bit_cnt + 3'd1;
                if (bit_cnt == 3'd7) begin
                    byte_cnt <= byte_cnt + BYTE_CNT_W'(1);
                end
            end
        end
    end

endmodule

// File: tb/tb_spi_rx_word_assembler.sv
// Directed bench for spi_rx_word_assembler: vector table plus multi-cycle corner sequences.
// Define SPI_RX_TIMEOUT_EN to also exercise the stall timeout with TIMEOUT_CYC=50.
module tb_spi_rx_word_assembler;
  import spi_pkg::*;

  localparam int W = 16;
`ifdef SPI_RX_TIMEOUT_EN
  localparam int TO_CYC = 50;
`else
  localparam int TO_CYC = 100000;
`endif

  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic         sclk = 1'b0;
  logic         mosi = 1'b0;
  logic         ss = 1'b1;
  logic [W-1:0] rx_data;
  logic         rx_valid;
  logic         rx_busy;
  logic         frame_err;
  rx_state_t    rx_state;

  spi_rx_word_assembler #(
    .BYTES_PER_WORD(2),
    .SYNC_STAGES(2),
    .TIMEOUT_CYC(TO_CYC)
  ) dut (
    .clk(clk),
    .reset(reset),
    .sclk(sclk),
    .mosi(mosi),
    .ss(ss),
    .rx_data(rx_data),
    .rx_valid(rx_valid),
    .rx_busy(rx_busy),
    .frame_err(frame_err),
    .rx_state(rx_state)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass = 0;
  int valid_cnt = 0;
  int err_cnt = 0;
  logic [W-1:0] exp_q[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  // Scoreboard: every rx_valid pulse must match the next expected word.
  always @(negedge clk) begin
    if (frame_err === 1'b1) err_cnt++;
    if (rx_valid === 1'b1) begin
      valid_cnt++;
      if (exp_q.size() == 0) begin
        n_checks++;
        $display("FAIL unexpected_valid: got data %h expected no word", rx_data);
      end else begin
        check("rx_data_sb", 32'(rx_data), 32'(exp_q.pop_front()));
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic send_bit(input logic b);
    mosi = b;
    tick(4);
    sclk = 1'b1;
    tick(4);
    sclk = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b);
    for (int i = 7; i >= 0; i--) send_bit(b[i]);
  endtask

  task automatic frame_start();
    ss = 1'b0;
    tick(4);
  endtask

  task automatic frame_end();
    tick(4);
    ss = 1'b1;
    tick(8);
  endtask

  typedef struct {
    logic [7:0]   b0;
    logic [7:0]   b1;
    logic [W-1:0] exp;
  } vec_t;

  vec_t vecs[5];

  initial begin
    int v0;
    int e0;
    int lat;
    logic [W-1:0] w;

    vecs[0] = '{8'h12, 8'h34, 16'h1234};
    vecs[1] = '{8'h00, 8'h00, 16'h0000};
    vecs[2] = '{8'hFF, 8'hFF, 16'hFFFF};
    vecs[3] = '{8'h80, 8'h01, 16'h8001};
    vecs[4] = '{8'hC3, 8'h3C, 16'hC33C};

    tick(5);
    reset = 1'b0;
    tick(2);
    check("reset_rx_data", 32'(rx_data), 32'h0);
    check("reset_rx_valid", 32'(rx_valid), 32'h0);
    check("reset_rx_busy", 32'(rx_busy), 32'h0);
    check("reset_frame_err", 32'(frame_err), 32'h0);

    // Single-word frames from the table.
    for (int i = 0; i < 5; i++) begin
      v0 = valid_cnt;
      e0 = err_cnt;
      exp_q.push_back(vecs[i].exp);
      frame_start();
      send_byte(vecs[i].b0);
      check("busy_in_frame", 32'(rx_busy), 32'h1);
      send_byte(vecs[i].b1);
      frame_end();
      check("vec_valid_count", 32'(valid_cnt - v0), 32'd1);
      check("vec_no_err", 32'(err_cnt - e0), 32'd0);
      check("vec_rx_data", 32'(rx_data), 32'(vecs[i].exp));
      check("vec_idle_busy", 32'(rx_busy), 32'h0);
    end

    // Back-to-back words with no ss toggle.
    v0 = valid_cnt;
    exp_q.push_back(16'hABCD);
    exp_q.push_back(16'h007F);
    frame_start();
    send_byte(8'hAB);
    send_byte(8'hCD);
    send_byte(8'h00);
    send_byte(8'h7F);
    frame_end();
    check("b2b_valid_count", 32'(valid_cnt - v0), 32'd2);
    check("b2b_rx_data", 32'(rx_data), 32'h007F);

    // Partial frame: 5 bits then release.
    v0 = valid_cnt;
    e0 = err_cnt;
    frame_start();
    for (int i = 0; i < 5; i++) send_bit(1'b1);
    frame_end();
    check("partial_err_pulse", 32'(err_cnt - e0), 32'd1);
    check("partial_no_valid", 32'(valid_cnt - v0), 32'd0);
    check("partial_rx_data_kept", 32'(rx_data), 32'h007F);

    // Select with zero bits taken: no error.
    e0 = err_cnt;
    frame_start();
    frame_end();
    check("empty_frame_no_err", 32'(err_cnt - e0), 32'd0);

    // sclk toggling while ss is inactive.
    v0 = valid_cnt;
    e0 = err_cnt;
    for (int i = 0; i < 16; i++) begin
      send_bit(1'b1);
      if (i == 8) check("ss_high_busy_mid", 32'(rx_busy), 32'h0);
    end
    tick(8);
    check("ss_high_no_valid", 32'(valid_cnt - v0), 32'd0);
    check("ss_high_no_err", 32'(err_cnt - e0), 32'd0);
    check("ss_high_busy", 32'(rx_busy), 32'h0);

    // Pin-to-valid latency on the final bit: SYNC_STAGES+2 cycles.
    exp_q.push_back(16'h9A5B);
    frame_start();
    send_byte(8'h9A);
    w = 16'h005B;
    for (int i = 7; i >= 1; i--) send_bit(w[i]);
    mosi = w[0];
    tick(4);
    sclk = 1'b1;
    lat = 1;
    while (lat <= 20) begin
      @(negedge clk);
      if (rx_valid === 1'b1) break;
      lat++;
    end
    check("pin_to_valid_latency", 32'(lat), 32'd4);
    check("latency_rx_data", 32'(rx_data), 32'h9A5B);
    tick(3);
    sclk = 1'b0;
    frame_end();

    // ss falling and first sclk rise arriving together: bit is kept.
    w = 16'hB00F;
    exp_q.push_back(w);
    mosi = w[15];
    ss = 1'b0;
    sclk = 1'b1;
    tick(4);
    sclk = 1'b0;
    for (int i = 14; i >= 0; i--) send_bit(w[i]);
    frame_end();
    check("coincident_start_data", 32'(rx_data), 32'hB00F);

    // Reset after 11 bits: everything clears silently.
    v0 = valid_cnt;
    e0 = err_cnt;
    frame_start();
    send_byte(8'h12);
    for (int i = 0; i < 3; i++) send_bit(1'b1);
    reset = 1'b1;
    tick(1);
    check("midreset_rx_data", 32'(rx_data), 32'h0);
    check("midreset_rx_valid", 32'(rx_valid), 32'h0);
    check("midreset_rx_busy", 32'(rx_busy), 32'h0);
    check("midreset_frame_err", 32'(frame_err), 32'h0);
    ss = 1'b1;
    tick(3);
    reset = 1'b0;
    tick(8);
    check("midreset_no_err", 32'(err_cnt - e0), 32'd0);
    check("midreset_no_valid", 32'(valid_cnt - v0), 32'd0);
    exp_q.push_back(16'h5AA5);
    frame_start();
    send_byte(8'h5A);
    send_byte(8'hA5);
    frame_end();
    check("post_reset_rx_data", 32'(rx_data), 32'h5AA5);

`ifdef SPI_RX_TIMEOUT_EN
    // Stall after 3 bits: timeout aborts, then bits are ignored until ss toggles.
    v0 = valid_cnt;
    e0 = err_cnt;
    frame_start();
    for (int i = 0; i < 3; i++) send_bit(1'b1);
    tick(60);
    check("timeout_err_pulse", 32'(err_cnt - e0), 32'd1);
    check("timeout_wait_busy", 32'(rx_busy), 32'h1);
    for (int i = 0; i < 16; i++) send_bit(1'b1);
    check("timeout_ignored_bits", 32'(valid_cnt - v0), 32'd0);
    frame_end();
    check("timeout_release_idle", 32'(rx_busy), 32'h0);
    exp_q.push_back(16'h1357);
    frame_start();
    send_byte(8'h13);
    send_byte(8'h57);
    frame_end();
    check("timeout_recover_data", 32'(rx_data), 32'h1357);
`endif

    tick(4);
    check("exp_q_drained", 32'(exp_q.size()), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
